// File: rtl/mmio_mem_pkg.sv
// Shared definitions for the mmio_mem data-memory front end: default I/O
// window addresses, the "no button pressed" code, the I/O register select
// encoding and the debounce counter sizing helper.
package mmio_mem_pkg;

    localparam logic [15:0] DEF_BTN_STATE_ADDR = 16'hFFFF;
    localparam logic [15:0] DEF_BTN_EVENT_ADDR = 16'hFFFE;
    localparam logic [15:0] DEF_BTN_RAW_ADDR   = 16'hFFFD;

    // Button state code reported when no debounced button is pressed.
    localparam int BTN_CODE_NONE = 0;

    // Which on-block register, if any, port B is addressing.
    typedef enum logic [1:0] {
        IO_NONE,
        IO_STATE,
        IO_EVENT,
        IO_RAW
    } io_sel_e;

    // Debounce counter width: must hold 0 .. cycles-1, and never be zero bits.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mmio_mem_if.sv
// CPU data-memory bus: port A read-only, port B read/write, plus the raw
// memory readback. The CPU side is the master, mmio_mem is the slave.
interface mmio_mem_if #(
    parameter int WIDTH = 16
);
    logic             we_b;
    logic             reading_for_load;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] addr_a;
    logic [WIDTH-1:0] addr_b;
    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;
    logic [WIDTH-1:0] memdata;

    modport master (
        output we_b, reading_for_load, data_b, addr_a, addr_b,
        input  q_a, q_b, memdata
    );

    modport slave (
        input  we_b, reading_for_load, data_b, addr_a, addr_b,
        output q_a, q_b, memdata
    );
endinterface

// File: rtl/basic_mem.sv
// Word-addressed data RAM: asynchronous reads on both ports, synchronous
// write on port B only.
module basic_mem #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             we_b,
    input  logic             reading_for_load,
    input  logic [WIDTH-1:0] addr_a,
    input  logic [WIDTH-1:0] addr_b,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b
);
    logic [WIDTH-1:0] mem [0:(2**WIDTH)-1];

    // Load-read qualifier is part of the CPU interface but does not change
    // how this array is read.
    logic unused_reading_for_load;
    assign unused_reading_for_load = reading_for_load;

    assign q_a = mem[addr_a];
    assign q_b = mem[addr_b];

    // Port B write.
    // NOTE: the array has no reset branch; RAM contents are undefined after
    // reset, and resetting every word would turn the array into plain flops.
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= data_b;
        end
    end

endmodule

// File: rtl/mmio_mem_btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level (1 = released) and a single-cycle pulse on each accepted press.
module mmio_mem_btn_debounce
    import mmio_mem_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);
    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          sample;
    logic          differ;

    assign sample = sync[1];
    assign differ = (sample != level);
    // The level falls on this same edge, so the pulse lines up with it.
    assign press  = differ && (cnt == CNT_MAX) && !sample;

    // Bring the asynchronous button into the clock domain; idle is released.
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn_n};
        end
    end

    // Count consecutive disagreeing samples; accept the new level after a full run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (differ) begin
            if (cnt == CNT_MAX) begin
                level <= sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mmio_mem.sv
// Data-memory front end: port A passes straight to basic_mem; port B goes
// to RAM except for a small window of button I/O registers (state code,
// sticky press events with write-1-to-clear, debounced levels).
module mmio_mem
    import mmio_mem_pkg::*;
#(
    parameter int               WIDTH           = 16,
    parameter int               NUM_BTNS        = 3,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] BTN_STATE_ADDR  = WIDTH'(DEF_BTN_STATE_ADDR),
    parameter logic [WIDTH-1:0] BTN_EVENT_ADDR  = WIDTH'(DEF_BTN_EVENT_ADDR),
    parameter logic [WIDTH-1:0] BTN_RAW_ADDR    = WIDTH'(DEF_BTN_RAW_ADDR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_n,
    output logic                btn_irq,
    mmio_mem_if.slave           bus
);
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] event_q;
    logic [NUM_BTNS-1:0] clr;
    io_sel_e             io_sel;
    logic                io_hit;
    logic                mem_we;
    logic [WIDTH-1:0]    state_code;
    logic [WIDTH-1:0]    rd_data;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        mmio_mem_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

    // I/O writes must never land in RAM.
    assign io_hit = (io_sel != IO_NONE);
    assign mem_we = bus.we_b & ~io_hit;

    basic_mem #(
        .WIDTH(WIDTH)
    ) u_mem (
        .clk              (clk),
        .we_b             (mem_we),
        .reading_for_load (bus.reading_for_load),
        .addr_a           (bus.addr_a),
        .addr_b           (bus.addr_b),
        .data_b           (bus.data_b),
        .q_a              (bus.q_a),
        .q_b              (bus.memdata)
    );

    // Decode port B address into the I/O register it selects.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        io_sel = IO_NONE;
        if (bus.addr_b == BTN_STATE_ADDR) begin
            io_sel = IO_STATE;
        end else if (bus.addr_b == BTN_EVENT_ADDR) begin
            io_sel = IO_EVENT;
        end else if (bus.addr_b == BTN_RAW_ADDR) begin
            io_sel = IO_RAW;
        end
    end

    // Priority encode pressed buttons: bit 0 wins, code is index+1.
    always_comb begin
        state_code = WIDTH'(BTN_CODE_NONE);
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (!level[i]) begin
                state_code = WIDTH'(i + 1);
            end
        end
    end

    // Write-1-to-clear mask from a port B write to the event register.
    always_comb begin
        clr = '0;
        if (bus.we_b && (io_sel == IO_EVENT)) begin
            clr = bus.data_b[NUM_BTNS-1:0];
        end
    end

    // Port B read mux: I/O registers zero-extended, otherwise RAM.
    always_comb begin
        rd_data = '0;
        case (io_sel)
            IO_STATE: rd_data = state_code;
            IO_EVENT: rd_data[NUM_BTNS-1:0] = event_q;
            IO_RAW:   rd_data[NUM_BTNS-1:0] = ~level;
            default:  rd_data = bus.memdata;
        endcase
    end

    // Sticky events (a press in the clearing cycle survives), the lagging
    // interrupt, and the registered port B readback that holds during writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_q <= '0;
            btn_irq <= 1'b0;
            bus.q_b <= '0;
        end else begin
            event_q <= (event_q & ~clr) | press;
            btn_irq <= |event_q;
            if (!bus.we_b) begin
                bus.q_b <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mmio_mem.sv
// Scoreboard bench for mmio_mem with 3 buttons and a 4-cycle debounce.
// Stimulus pushes expected port B/A read data into a queue; a monitor pops
// and compares one cycle later. Button behaviour comes from a sliding-window
// reference: a button's level flips once the last DEBOUNCE_CYCLES samples,
// seen two cycles late, all disagree with it.
module tb_mmio_mem;
    localparam int          W         = 16;
    localparam int          N         = 3;
    localparam int          D         = 4;
    localparam int          RAM_WORDS = 64;
    localparam logic [15:0] A_STATE   = 16'hFFFF;
    localparam logic [15:0] A_EVENT   = 16'hFFFE;
    localparam logic [15:0] A_RAW     = 16'hFFFD;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp_q;
        logic [15:0] addr_a;
        logic [15:0] exp_qa;
    } rd_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_n;
    logic         btn_irq;

    mmio_mem_if #(.WIDTH(W)) bus ();

    mmio_mem #(
        .WIDTH           (W),
        .NUM_BTNS        (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (btn_n),
        .btn_irq (btn_irq),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]  ram_m [0:RAM_WORDS-1];
    logic [N-1:0] hist [0:D];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_ev;
    logic         m_irq;
    logic [N-1:0] all_diff;
    logic [N-1:0] nxt_lvl;
    logic [N-1:0] m_press;
    logic [N-1:0] m_clr;

    always_comb begin
        all_diff = '1;
        for (int i = 0; i < N; i++) begin
            for (int k = 1; k <= D; k++) begin
                if (hist[k][i] == m_lvl[i]) all_diff[i] = 1'b0;
            end
        end
        nxt_lvl = m_lvl ^ all_diff;
        m_press = m_lvl & ~nxt_lvl;
        m_clr   = '0;
        if (bus.we_b && bus.addr_b == A_EVENT) m_clr = bus.data_b[N-1:0];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= D; k++) hist[k] <= '1;
            m_lvl <= '1;
            m_ev  <= '0;
            m_irq <= 1'b0;
        end else begin
            hist[0] <= btn_n;
            for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
            m_lvl <= nxt_lvl;
            m_ev  <= (m_ev & ~m_clr) | m_press;
            m_irq <= |m_ev;
        end
    end

    function automatic logic [15:0] state_code(input logic [N-1:0] pressed);
        for (int i = 0; i < N; i++) begin
            if (pressed[i]) return 16'(i + 1);
        end
        return 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        case (addr)
            A_STATE: return state_code(~m_lvl);
            A_EVENT: return {{(16-N){1'b0}}, m_ev};
            A_RAW:   return {{(16-N){1'b0}}, ~m_lvl};
            default: return ram_m[addr[5:0]];
        endcase
    endfunction

    function automatic logic [15:0] rand_addr();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0:       return A_STATE;
            1:       return A_EVENT;
            2:       return A_RAW;
            default: return 16'($urandom_range(0, RAM_WORDS - 1));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    rd_t         sb[$];
    logic        rd_issue  = 1'b0;
    logic        wr_issue  = 1'b0;
    logic        hold_en   = 1'b0;
    logic [15:0] hold_exp  = '0;
    logic        prev_read = 1'b0;
    logic [15:0] last_exp  = '0;

    task automatic issue_read(input logic [15:0] addr, input bit use_model, input logic [15:0] cexp);
        rd_t e;
        @(negedge clk); #1;
        bus.we_b             = 1'b0;
        bus.reading_for_load = 1'b1;
        bus.addr_b           = addr;
        bus.data_b           = 16'($urandom);
        bus.addr_a           = 16'($urandom_range(0, RAM_WORDS - 1));
        wr_issue             = 1'b0;
        rd_issue             = 1'b1;
        e.addr   = addr;
        e.exp_q  = use_model ? model_read(addr) : cexp;
        e.addr_a = bus.addr_a;
        e.exp_qa = ram_m[bus.addr_a[5:0]];
        sb.push_back(e);
        last_exp  = e.exp_q;
        prev_read = 1'b1;
        if (addr < RAM_WORDS) begin
            #1 check($sformatf("memdata@%h", addr), bus.memdata, ram_m[addr[5:0]]);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk); #1;
        bus.we_b             = 1'b1;
        bus.reading_for_load = 1'b0;
        bus.addr_b           = addr;
        bus.data_b           = data;
        rd_issue             = 1'b0;
        wr_issue             = 1'b1;
        hold_en              = prev_read;
        hold_exp             = last_exp;
        if (addr < RAM_WORDS) ram_m[addr[5:0]] = data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            bus.we_b  = 1'b0;
            rd_issue  = 1'b0;
            wr_issue  = 1'b0;
            prev_read = 1'b0;
        end
    endtask

    task automatic set_btn(input logic [N-1:0] v);
        idle(1);
        btn_n = v;
    endtask

    task automatic do_reset(input int hold);
        idle(1);
        last_exp = '0;
        #1 reset = 1'b0;
        #1;
        check("q_b_in_reset", bus.q_b, 0);
        check("irq_in_reset", btn_irq, 0);
        repeat (hold) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic rd_valid = 1'b0;
    logic wr_chk   = 1'b0;

    always @(posedge clk) begin
        rd_valid <= rd_issue;
        wr_chk   <= wr_issue && hold_en;
    end

    always @(negedge clk) begin
        rd_t e;
        check("btn_irq", btn_irq, m_irq);
        if (rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: read completed with nothing expected at %0t", $time);
            end else begin
                e = sb.pop_front();
                check($sformatf("q_b@%h", e.addr), bus.q_b, e.exp_q);
                check($sformatf("q_a@%h", e.addr_a), bus.q_a, e.exp_qa);
            end
        end
        if (wr_chk) check("q_b_hold", bus.q_b, hold_exp);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        reset                = 1'b0;
        btn_n                = '1;
        bus.we_b             = 1'b0;
        bus.reading_for_load = 1'b0;
        bus.data_b           = '0;
        bus.addr_a           = '0;
        bus.addr_b           = 16'h0010;
        #3;
        check("q_b_at_reset", bus.q_b, 0);
        check("irq_at_reset", btn_irq, 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        for (int a = 0; a < RAM_WORDS; a++) do_write(16'(a), 16'($urandom));
        issue_read(A_STATE, 0, 16'h0000);

        // RAM write then readback
        do_write(16'h0010, 16'hABCD);
        issue_read(16'h0010, 0, 16'hABCD);

        // single press on button 1
        set_btn(3'b101);
        idle(6);
        issue_read(A_STATE, 0, 16'h0002);
        issue_read(A_EVENT, 0, 16'h0002);
        issue_read(A_RAW,   0, 16'h0002);
        idle(1);
        check("irq_after_press", btn_irq, 1);

        // release sets no event; clear it
        set_btn(3'b111);
        idle(8);
        issue_read(A_EVENT, 0, 16'h0002);
        issue_read(A_RAW,   0, 16'h0000);
        do_write(A_EVENT, 16'h0002);
        issue_read(A_EVENT, 0, 16'h0000);

        // 3-cycle glitch on button 0 is rejected
        set_btn(3'b110);
        idle(2);
        set_btn(3'b111);
        idle(8);
        issue_read(A_EVENT, 0, 16'h0000);
        issue_read(A_STATE, 0, 16'h0000);

        // buttons 0 and 2 held: priority to button 0
        set_btn(3'b010);
        idle(6);
        issue_read(A_STATE, 0, 16'h0001);
        issue_read(A_EVENT, 0, 16'h0005);
        issue_read(A_RAW,   0, 16'h0005);
        do_write(A_EVENT, 16'h0001);
        issue_read(A_EVENT, 0, 16'h0004);

        // release button 2, clear its event
        set_btn(3'b110);
        idle(8);
        do_write(A_EVENT, 16'h0004);
        issue_read(A_EVENT, 0, 16'h0000);

        // re-press button 2; clear lands on the same edge as the press pulse
        set_btn(3'b010);
        idle(4);
        do_write(A_EVENT, 16'h0004);
        issue_read(A_EVENT, 0, 16'h0004);

        // I/O writes stay out of RAM; q_b holds during the write
        issue_read(16'h0010, 0, 16'hABCD);
        do_write(A_EVENT, 16'h1234);
        issue_read(16'h0010, 0, 16'hABCD);
        issue_read(A_EVENT, 0, 16'h0000);
        do_write(A_STATE, 16'hFFFF);
        do_write(A_RAW,   16'hFFFF);
        issue_read(A_STATE, 0, 16'h0001);
        issue_read(A_RAW,   0, 16'h0005);

        // reset with button 1 held: partial state gone, reported again later
        set_btn(3'b101);
        idle(8);
        do_reset(2);
        issue_read(A_EVENT, 0, 16'h0000);
        issue_read(A_STATE, 0, 16'h0000);
        idle(5);
        issue_read(A_EVENT, 0, 16'h0002);
        issue_read(A_STATE, 0, 16'h0002);

        // randomised traffic against the reference model
        repeat (400) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                set_btn(N'($urandom));
            end else if (r < 5) begin
                do_write(rand_addr(), 16'($urandom));
            end else begin
                issue_read(rand_addr(), 1, 16'h0000);
            end
        end
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
